// File: rtl/hazard_pkg.sv
// Shared definitions for the pipeline hazard detection unit:
// stall-sequencer state encoding and default register-number width.
package hazard_pkg;

    localparam int unsigned RWIDTH_DEFAULT = 5;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        STALL1 = 2'd1,
        STALL2 = 2'd2
    } state_e;

endpackage

// File: rtl/hazard_stall_fsm.sv
// Multi-cycle stall sequencer: start1 requests one stalled cycle, start2 two.
// Bubbles after the first are counted by state, not re-derived from flushed stages.
module hazard_stall_fsm
    import hazard_pkg::*;
(
    input  logic Clock,
    input  logic Reset,
    input  logic start1,
    input  logic start2,
    output logic stalling
);

    state_e state_q, state_d;

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d  = RUN;
        stalling = 1'b0;
        case (state_q)
            RUN: begin
                stalling = start1 | start2;
                state_d  = start2 ? STALL1 : RUN;
            end
            STALL1: begin
                stalling = 1'b1;
                state_d  = RUN;
            end
            // Reserved for a future 3-cycle hazard.
            STALL2: begin
                stalling = 1'b1;
                state_d  = STALL1;
            end
            default: begin
                stalling = 1'b0;
                state_d  = RUN;
            end
        endcase
    end

endmodule

// File: rtl/hazard_detection_unit.sv
// Stall/flush control for the five-stage pipeline (load-use and branch-in-ID hazards).
// Optional stall/flush statistics counters are enabled with HAZARD_STATS_EN.
module hazard_detection_unit
    import hazard_pkg::*;
#(
    parameter int unsigned rwidth = RWIDTH_DEFAULT,
    parameter int unsigned cwidth = 32
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic [rwidth-1:0] IF_ID_RegisterRs,
    input  logic [rwidth-1:0] IF_ID_RegisterRt,
    input  logic              ID_UsesRt,
    input  logic              ID_Branch,
    input  logic              ID_Branch_Taken,
    input  logic              ID_Jump,
    input  logic              ID_EX_MemRead,
    input  logic              ID_EX_RegWrite,
    input  logic [rwidth-1:0] ID_EX_WriteReg,
    input  logic              EX_MEM_MemRead,
    input  logic [rwidth-1:0] EX_MEM_WriteReg,
    output logic              PCWrite,
    output logic              IF_ID_Write,
    output logic              IF_ID_Flush,
    output logic              ID_EX_Flush
`ifdef HAZARD_STATS_EN
    ,
    output logic [cwidth-1:0] Stall_count,
    output logic [cwidth-1:0] Flush_count
`endif
);

    // A destination of $0 never creates a dependency.
    function automatic logic dep(input logic [rwidth-1:0] d,
                                 input logic [rwidth-1:0] rs,
                                 input logic [rwidth-1:0] rt,
                                 input logic              uses_rt);
        return (d != '0) && ((d == rs) || (uses_rt && (d == rt)));
    endfunction

    logic dep_ex, dep_mem;
    logic h_load_use, h_br_alu, h_br_load_ex, h_br_load_mem;
    logic start1, start2, stalling;

    assign dep_ex  = dep(ID_EX_WriteReg,  IF_ID_RegisterRs, IF_ID_RegisterRt, ID_UsesRt);
    assign dep_mem = dep(EX_MEM_WriteReg, IF_ID_RegisterRs, IF_ID_RegisterRt, ID_UsesRt);

    assign h_load_use    = !ID_Branch && ID_EX_MemRead && dep_ex;
    assign h_br_alu      = ID_Branch && ID_EX_RegWrite && !ID_EX_MemRead && dep_ex;
    assign h_br_load_ex  = ID_Branch && ID_EX_MemRead && dep_ex;
    assign h_br_load_mem = ID_Branch && EX_MEM_MemRead && dep_mem;

    assign start1 = h_load_use | h_br_alu | h_br_load_mem;
    assign start2 = h_br_load_ex;

    hazard_stall_fsm u_stall_fsm (
        .Clock    (Clock),
        .Reset    (Reset),
        .start1   (start1),
        .start2   (start2),
        .stalling (stalling)
    );

    always_comb begin
        PCWrite     = 1'b1;
        IF_ID_Write = 1'b1;
        IF_ID_Flush = ID_Jump | (ID_Branch & ID_Branch_Taken);
        ID_EX_Flush = 1'b0;
        if (Reset) begin
            PCWrite     = 1'b0;
            IF_ID_Write = 1'b0;
            IF_ID_Flush = 1'b1;
            ID_EX_Flush = 1'b1;
        end else if (stalling) begin
            // Stall beats flush: the branch resolves on the first non-stalling cycle.
            PCWrite     = 1'b0;
            IF_ID_Write = 1'b0;
            IF_ID_Flush = 1'b0;
            ID_EX_Flush = 1'b1;
        end
    end

`ifdef HAZARD_STATS_EN
    logic [cwidth-1:0] stall_cnt_q, stall_cnt_d;
    logic [cwidth-1:0] flush_cnt_q, flush_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (stalling && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
        if (IF_ID_Flush && (flush_cnt_q != '1)) begin
            flush_cnt_d = flush_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign Stall_count = stall_cnt_q;
    assign Flush_count = flush_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_detection_unit.sv
// Self-checking bench for hazard_detection_unit: directed scenarios plus random stimulus
// against a bubble-count reference model. Counter checks are active with HAZARD_STATS_EN.
module tb_hazard_detection_unit;

    localparam int unsigned RW = 5;
    localparam int unsigned CW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic [RW-1:0] rs, rt, ex_wr, mem_wr;
    logic          uses_rt, br, taken, jmp, ex_mr, ex_rw, mem_mr;
    logic          pc_write, ifid_write, ifid_flush, idex_flush;
`ifdef HAZARD_STATS_EN
    logic [CW-1:0] stall_count, flush_count;
`endif

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;
    int          pending = 0;
    int unsigned m_stall = 0;
    int unsigned m_flush = 0;

    always #5 clk = ~clk;

    hazard_detection_unit #(.rwidth(RW), .cwidth(CW)) dut (
        .Clock            (clk),
        .Reset            (rst),
        .IF_ID_RegisterRs (rs),
        .IF_ID_RegisterRt (rt),
        .ID_UsesRt        (uses_rt),
        .ID_Branch        (br),
        .ID_Branch_Taken  (taken),
        .ID_Jump          (jmp),
        .ID_EX_MemRead    (ex_mr),
        .ID_EX_RegWrite   (ex_rw),
        .ID_EX_WriteReg   (ex_wr),
        .EX_MEM_MemRead   (mem_mr),
        .EX_MEM_WriteReg  (mem_wr),
        .PCWrite          (pc_write),
        .IF_ID_Write      (ifid_write),
        .IF_ID_Flush      (ifid_flush),
        .ID_EX_Flush      (idex_flush)
`ifdef HAZARD_STATS_EN
        ,
        .Stall_count      (stall_count),
        .Flush_count      (flush_count)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Number of stalled cycles the instruction in ID must wait, straight from the hazard rules.
    function automatic int hazard_cycles();
        bit dep_ex, dep_mem;
        dep_ex  = (ex_wr  != 0) && ((ex_wr  == rs) || (uses_rt && ex_wr  == rt));
        dep_mem = (mem_wr != 0) && ((mem_wr == rs) || (uses_rt && mem_wr == rt));
        if (br && ex_mr && dep_ex)  return 2;
        if (ex_mr && dep_ex)        return 1;
        if (br && ex_rw && dep_ex)  return 1;
        if (br && mem_mr && dep_mem) return 1;
        return 0;
    endfunction

    task automatic idle();
        rst = 1'b0; rs = '0; rt = '0; ex_wr = '0; mem_wr = '0;
        uses_rt = 1'b0; br = 1'b0; taken = 1'b0; jmp = 1'b0;
        ex_mr = 1'b0; ex_rw = 1'b0; mem_mr = 1'b0;
    endtask

    // Called at a falling edge with inputs already driven; checks, then advances one clock.
    task automatic cycle(input string tag);
        logic [3:0] exp;
        int         hc;
        bit         flush;
        #1;
        hc    = hazard_cycles();
        flush = 1'b0;
        if (rst)                exp = 4'b0011;
        else if (pending > 0)   exp = 4'b0001;
        else if (hc > 0)        exp = 4'b0001;
        else begin
            flush = jmp | (br & taken);
            exp   = {2'b11, flush, 1'b0};
        end
        check(tag, {28'd0, pc_write, ifid_write, ifid_flush, idex_flush}, {28'd0, exp});
`ifdef HAZARD_STATS_EN
        check({tag, "_stall_cnt"}, stall_count, m_stall);
        check({tag, "_flush_cnt"}, flush_count, m_flush);
`endif
        @(posedge clk);
        if (rst) begin
            pending = 0; m_stall = 0; m_flush = 0;
        end else if (pending > 0) begin
            pending--; m_stall++;
        end else if (hc > 0) begin
            pending = hc - 1; m_stall++;
        end else if (flush) begin
            m_flush++;
        end
        @(negedge clk);
    endtask

    initial begin
        idle();
        rst = 1'b1;
        @(negedge clk);
        cycle("reset0");
        cycle("reset1");
        idle();

        // lw $2 in EX, add $3,$2,$4 in ID
        ex_mr = 1'b1; ex_rw = 1'b1; ex_wr = 5'd2; rs = 5'd2; rt = 5'd4; uses_rt = 1'b1;
        cycle("load_use");
        ex_mr = 1'b0; ex_rw = 1'b0; ex_wr = '0;
        cycle("load_use_after");

        idle(); ex_mr = 1'b1; ex_wr = 5'd0; rs = 5'd0;
        cycle("reg_zero");

        idle(); ex_mr = 1'b1; ex_wr = 5'd5; rt = 5'd5; rs = 5'd1; uses_rt = 1'b0;
        cycle("rt_not_read");

        // beq $2,$0 in ID, lw $2 in EX, taken
        idle(); br = 1'b1; taken = 1'b1; rs = 5'd2; rt = 5'd0; uses_rt = 1'b1;
        ex_mr = 1'b1; ex_rw = 1'b1; ex_wr = 5'd2;
        cycle("br_load_1");
        ex_mr = 1'b0; ex_rw = 1'b0; ex_wr = '0; mem_mr = 1'b1; mem_wr = 5'd2;
        cycle("br_load_2");
        mem_mr = 1'b0; mem_wr = '0;
        cycle("br_load_resolve");

        idle(); br = 1'b1; ex_rw = 1'b1; ex_wr = 5'd7; rs = 5'd7; uses_rt = 1'b1;
        cycle("br_alu");
        ex_rw = 1'b0; ex_wr = '0;
        cycle("br_alu_resolve");

        idle(); jmp = 1'b1;
        cycle("jump");
        jmp = 1'b0;
        cycle("jump_after");

        // Reset during the first stall of a branch-on-load
        idle(); br = 1'b1; taken = 1'b1; rs = 5'd2; ex_mr = 1'b1; ex_wr = 5'd2; rst = 1'b1;
        cycle("reset_mid_stall");
        idle();
        cycle("after_reset");

        for (int unsigned i = 0; i < 400; i++) begin
            rst     = ($urandom_range(39) == 0);
            rs      = RW'($urandom_range(7));
            rt      = RW'($urandom_range(7));
            ex_wr   = RW'($urandom_range(7));
            mem_wr  = RW'($urandom_range(7));
            uses_rt = 1'($urandom);
            br      = 1'($urandom);
            taken   = 1'($urandom);
            jmp     = ($urandom_range(3) == 0);
            ex_mr   = 1'($urandom);
            ex_rw   = 1'($urandom);
            mem_mr  = 1'($urandom);
            cycle("random");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/hazard_detection_unit.md
# hazard_detection_unit

Generates the stall and flush controls for the five-stage pipeline: `PCWrite`, `IF_ID_Write`, `IF_ID_Flush`, and the `ID_EX_Flush` that the ID/EX register consumes to insert a bubble. It watches the instruction in ID, the instructions in EX and MEM, and the branch resolution done in ID. A small FSM sequences multi-cycle stalls, so bubbles are counted by state rather than re-derived from stage registers that have already been flushed.

## Interface
Parameters:
- `rwidth`, 5, register-number width
- `cwidth`, 32, statistics counter width (only with `HAZARD_STATS_EN`)

Ports:
- `Clock`  in  1  single clock; all state changes on its rising edge
- `Reset`  in  1  synchronous, active-high reset; sampled on the rising edge of `Clock`
- `IF_ID_RegisterRs`, `IF_ID_RegisterRt`  in  rwidth  source registers of the instruction in ID
- `ID_UsesRt`  in  1  the instruction in ID reads Rt (R-type, beq, bne, sw)
- `ID_Branch`  in  1  conditional branch in ID
- `ID_Branch_Taken`  in  1  ID comparator result; meaningful only when not stalling
- `ID_Jump`  in  1  unconditional jump in ID
- `ID_EX_MemRead`, `ID_EX_RegWrite`  in  1  control bits of the instruction in EX
- `ID_EX_WriteReg`  in  rwidth  destination of the instruction in EX, after the RegDst mux
- `EX_MEM_MemRead`  in  1  the instruction in MEM is a load
- `EX_MEM_WriteReg`  in  rwidth  destination of the instruction in MEM
- `PCWrite`  out  1  PC may update
- `IF_ID_Write`  out  1  IF/ID may load
- `IF_ID_Flush`  out  1  zero IF/ID (squash the fetched instruction)
- `ID_EX_Flush`  out  1  zero the ID/EX control bits (bubble)
- `Stall_count`, `Flush_count`  out  cwidth  present only with `HAZARD_STATS_EN`

## Operation
Match terms (a destination of 0 never matches):
- `mRs(d)` = `d != 0 && d == IF_ID_RegisterRs`
- `mRt(d)` = `d != 0 && ID_UsesRt && d == IF_ID_RegisterRt`
- `dep(d)` = `mRs(d) || mRt(d)`

Hazard conditions, evaluated in RUN:
- H_LOAD_USE: `ID_EX_MemRead && dep(ID_EX_WriteReg)`. Stall 1 cycle. If `ID_Branch` is also set, this is H_BR_LOAD_EX instead.
- H_BR_ALU: `ID_Branch && ID_EX_RegWrite && !ID_EX_MemRead && dep(ID_EX_WriteReg)`. Stall 1 cycle.
- H_BR_LOAD_EX: `ID_Branch && ID_EX_MemRead && dep(ID_EX_WriteReg)`. Stall 2 cycles.
- H_BR_LOAD_MEM: `ID_Branch && EX_MEM_MemRead && dep(EX_MEM_WriteReg)`. Stall 1 cycle.

FSM states: RUN, STALL2, STALL1.
- RUN, any 1-cycle hazard: assert stall outputs this cycle; next state RUN.
- RUN, H_BR_LOAD_EX: assert stall outputs this cycle; next state STALL1. This gives 2 bubbles in total.
- STALL1: stall outputs forced regardless of inputs; next state RUN. Hazards are re-evaluated in RUN.
- STALL2: reserved for a future 3-cycle case; it goes to STALL1. Unreachable states go to RUN.

Output values:
- Stall outputs: `PCWrite=0`, `IF_ID_Write=0`, `ID_EX_Flush=1`, `IF_ID_Flush=0`.
- No stall in RUN: `PCWrite=1`, `IF_ID_Write=1`, `ID_EX_Flush=0`, and `IF_ID_Flush = ID_Jump || (ID_Branch && ID_Branch_Taken)`.

Priority:
- A stall always beats a flush. `ID_Branch_Taken` is ignored in any stalling cycle.
- The branch resolves on the first non-stalling cycle.

Reset:
- While `Reset` is sampled high, outputs are `PCWrite=0`, `IF_ID_Write=0`, `IF_ID_Flush=1`, `ID_EX_Flush=1`.
- On the edge: state goes to RUN and counters go to 0.
- Reset asserted mid-stall aborts the stall. The first cycle after reset is RUN.

## Timing
- Outputs are combinational from inputs and state, with zero latency, so a hazard is suppressed in the cycle it appears.
- State and counters update on the rising edge of `Clock`.
- A 1-cycle hazard produces exactly 1 stalled cycle; H_BR_LOAD_EX produces exactly 2 consecutive stalled cycles.
- `IF_ID_Flush` is high for exactly one cycle per taken branch or jump.
- No combinational path from `IF_ID_Flush` to any input.

## Configuration
- `HAZARD_STATS_EN` defined:
  - `Stall_count` increments once per stalled cycle.
  - `Flush_count` increments once per cycle with `IF_ID_Flush=1` and `Reset=0`.
  - Both saturate at all-ones and clear on `Reset`.
- `HAZARD_STATS_EN` undefined: both ports and both counters are absent; all other behaviour is identical.

## Structure
- Shared package `hazard_pkg` holds the state encoding (RUN=2'd0, STALL2=2'd2, STALL1=2'd1) and the default `rwidth`.
- One sub-module, `hazard_stall_fsm`:
  - inputs: `Clock`, `Reset`, `start1`, `start2`
  - output: `stalling`
  - `start1` requests a 1-cycle stall; `start2` requests a 2-cycle stall.
- Dependency matching and output muxing live in the top.

## Test plan
- Load-use: `lw $2` in EX (`ID_EX_MemRead=1`, `ID_EX_WriteReg=2`), `add $3,$2,$4` in ID → one cycle with `PCWrite=0`, `IF_ID_Write=0`, `ID_EX_Flush=1`; normal the next cycle.
- Register zero: `ID_EX_MemRead=1`, `ID_EX_WriteReg=0`, Rs=0 → no stall.
- Rt not read: `ID_EX_WriteReg=5`, Rt=5, `ID_UsesRt=0` → no stall.
- Branch on load: `beq $2,$0` in ID, `lw $2` in EX, `ID_Branch_Taken=1` → 2 stalled cycles with `IF_ID_Flush=0` throughout; the 3rd cycle has `IF_ID_Flush=1`. With stats, `Stall_count=2`, `Flush_count=1`.
- Branch on ALU result: `ID_EX_RegWrite=1`, `ID_EX_WriteReg=7`, `beq $7` in ID → 1 stall. Jump with no hazard → `IF_ID_Flush=1` for 1 cycle, `PCWrite=1`.
- Reset: assert `Reset` in the first stall of H_BR_LOAD_EX → flush outputs while `Reset` is high; state is RUN on release; counters are 0.
